// File: rtl/pipe_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath (master) and pipe_ctrl (slave).
// Carries hazard inputs, register enables/clears, stall cause and performance counters.
interface pipe_ctrl_if #(
  parameter int XLEN_REG = 5
);
  logic [XLEN_REG-1:0] id_rs1;
  logic [XLEN_REG-1:0] id_rs2;
  logic [XLEN_REG-1:0] ex_rd;
  logic                ex_memread;
  logic                ex_muldiv_start;
  logic                ex_branch_taken;
  logic                imem_ready;
  logic                mem_req;
  logic                dmem_ready;

  logic                en_pc;
  logic                en_ifid;
  logic                en_idex;
  logic                en_exmem;
  logic                en_memwb;
  logic                clr_ifid_n;
  logic                clr_idex_n;
  logic                clr_exmem_n;
  logic [1:0]          stall_cause;
  logic [31:0]         stall_cycles;
  logic [31:0]         flush_count;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_memread, ex_muldiv_start, ex_branch_taken,
           imem_ready, mem_req, dmem_ready,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           clr_ifid_n, clr_idex_n, clr_exmem_n, stall_cause, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_memread, ex_muldiv_start, ex_branch_taken,
           imem_ready, mem_req, dmem_ready,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           clr_ifid_n, clr_idex_n, clr_exmem_n, stall_cause, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline hazard controller: load-use/fetch bubbles, branch flush, mul/div and memory freezes.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters; otherwise they read 0.
module pipe_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int XLEN_REG      = 5
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_if.slave     pif
);

  typedef enum logic [1:0] {RUN, MULDIV, MEMWAIT} state_e;

  localparam logic [3:0]          CNT_INIT = 4'(MULDIV_CYCLES - 1);
  localparam logic [XLEN_REG-1:0] REG_ZERO = '0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       en_front, en_back, clr_ifid, clr_idex;
  logic [1:0] cause;
  logic       mem_stall, load_use;

  assign mem_stall = pif.mem_req && !pif.dmem_ready;
  assign load_use  = pif.ex_memread && (pif.ex_rd != REG_ZERO) &&
                     ((pif.ex_rd == pif.id_rs1) || (pif.ex_rd == pif.id_rs2));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_front = 1'b1;
    en_back  = 1'b1;
    clr_ifid = 1'b1;
    clr_idex = 1'b1;
    cause    = 2'd0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          en_front = 1'b0;
          en_back  = 1'b0;
          cause    = 2'd3;
          state_d  = MEMWAIT;
        end else if (pif.ex_muldiv_start) begin
          en_front = 1'b0;
          en_back  = 1'b0;
          cause    = 2'd2;
          if (MULDIV_CYCLES > 1) begin
            state_d = MULDIV;
            cnt_d   = CNT_INIT;
          end
        end else if (pif.ex_branch_taken) begin
          clr_ifid = 1'b0;
          clr_idex = 1'b0;
        end else if (load_use || !pif.imem_ready) begin
          en_front = 1'b0;
          clr_idex = 1'b0;
          cause    = 2'd1;
        end
      end
      MULDIV: begin
        if (cnt_q != 4'd0) begin
          en_front = 1'b0;
          en_back  = 1'b0;
          cause    = 2'd2;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          // A branch held back by the freeze takes effect on the release cycle.
          clr_ifid = !pif.ex_branch_taken;
          clr_idex = !pif.ex_branch_taken;
          state_d  = RUN;
        end
      end
      MEMWAIT: begin
        if (!pif.dmem_ready) begin
          en_front = 1'b0;
          en_back  = 1'b0;
          cause    = 2'd3;
        end else begin
          clr_ifid = !pif.ex_branch_taken;
          clr_idex = !pif.ex_branch_taken;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pif.en_pc       = !rst && en_front;
  assign pif.en_ifid     = !rst && en_front;
  assign pif.en_idex     = !rst && en_back;
  assign pif.en_exmem    = !rst && en_back;
  assign pif.en_memwb    = !rst && en_back;
  assign pif.clr_ifid_n  = !rst && clr_ifid;
  assign pif.clr_idex_n  = !rst && clr_idex;
  assign pif.clr_exmem_n = !rst;
  assign pif.stall_cause = rst ? 2'd0 : cause;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;
  logic        flush_run;

  assign flush_run = (state_q == RUN) && !mem_stall && !pif.ex_muldiv_start && pif.ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (cause != 2'd0) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_run)     flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign pif.stall_cycles = stall_cycles_q;
  assign pif.flush_count  = flush_count_q;
`else
  assign pif.stall_cycles = 32'd0;
  assign pif.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MULDIV_CYCLES=4, XLEN_REG=5).
// Control word checked per cycle: {en_pc,en_ifid,en_idex,en_exmem,en_memwb, clr_ifid_n,clr_idex_n,clr_exmem_n, stall_cause}.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [9:0] W_RESET  = 10'b00000_000_00;
  localparam logic [9:0] W_RUN    = 10'b11111_111_00;
  localparam logic [9:0] W_BUBBLE = 10'b00111_101_01;
  localparam logic [9:0] W_BRANCH = 10'b11111_001_00;
  localparam logic [9:0] W_FRZ_MD = 10'b00000_111_10;
  localparam logic [9:0] W_FRZ_MW = 10'b00000_111_11;

  pipe_ctrl_if #(.XLEN_REG(5)) pif ();

  pipe_ctrl #(.MULDIV_CYCLES(4), .XLEN_REG(5)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  always #5 clk = ~clk;

  logic [9:0] ctl;
  assign ctl = {pif.en_pc, pif.en_ifid, pif.en_idex, pif.en_exmem, pif.en_memwb,
                pif.clr_ifid_n, pif.clr_idex_n, pif.clr_exmem_n, pif.stall_cause};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Drive one cycle's inputs just after the falling edge, then let them settle.
  task automatic apply(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic md, input logic br,
                       input logic im, input logic mq, input logic dr);
    @(negedge clk);
    pif.ex_memread      = mr;
    pif.ex_rd           = rd;
    pif.id_rs1          = rs1;
    pif.id_rs2          = rs2;
    pif.ex_muldiv_start = md;
    pif.ex_branch_taken = br;
    pif.imem_ready      = im;
    pif.mem_req         = mq;
    pif.dmem_ready      = dr;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    pif.ex_memread = 1'b0; pif.ex_rd = 5'd3; pif.id_rs1 = 5'd1; pif.id_rs2 = 5'd2;
    pif.ex_muldiv_start = 1'b0; pif.ex_branch_taken = 1'b0; pif.imem_ready = 1'b1;
    pif.mem_req = 1'b0; pif.dmem_ready = 1'b1;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(W_RESET));
    chk("reset_stall_cycles", pif.stall_cycles, 32'd0);
    chk("reset_flush_count", pif.flush_count, 32'd0);
    @(negedge clk); rst = 1'b0;
    idle();                                                            chk("run_idle", 32'(ctl), 32'(W_RUN));

    apply(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   chk("loaduse_rs2", 32'(ctl), 32'(W_BUBBLE));
    idle();                                                            chk("loaduse_one_cycle", 32'(ctl), 32'(W_RUN));
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   chk("loaduse_rd0", 32'(ctl), 32'(W_RUN));
    apply(1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   chk("loaduse_rs1", 32'(ctl), 32'(W_BUBBLE));
    apply(1'b0, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   chk("no_load_match", 32'(ctl), 32'(W_RUN));
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   chk("fetch_bubble", 32'(ctl), 32'(W_BUBBLE));
    apply(1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);   chk("branch_over_loaduse", 32'(ctl), 32'(W_BRANCH));

    // Mul/div held high through release: 4 frozen cycles, release ignores start.
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("muldiv_c%0d", i), 32'(ctl), 32'(i < 4 ? W_FRZ_MD : W_RUN));
    end
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   chk("muldiv_back_run", 32'(ctl), 32'(W_BUBBLE));

    // Branch during the mul/div freeze waits for the release cycle.
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);   chk("md_br_c0", 32'(ctl), 32'(W_FRZ_MD));
    for (int i = 1; i < 4; i++) begin
      apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk($sformatf("md_br_frozen_c%0d", i), 32'(ctl), 32'(W_FRZ_MD));
    end
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);   chk("md_br_release", 32'(ctl), 32'(W_BRANCH));
    idle();                                                            chk("md_br_after", 32'(ctl), 32'(W_RUN));

    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("memwait_c%0d", i), 32'(ctl), 32'(W_FRZ_MW));
    end
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);   chk("memwait_release", 32'(ctl), 32'(W_RUN));
    idle();                                                            chk("memwait_after", 32'(ctl), 32'(W_RUN));

    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   chk("simul_memwait", 32'(ctl), 32'(W_FRZ_MW));
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);   chk("simul_release_br", 32'(ctl), 32'(W_BRANCH));
    idle();                                                            chk("simul_after", 32'(ctl), 32'(W_RUN));

    // Reset while the mul/div counter sits at 2.
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);   chk("rstmd_c0", 32'(ctl), 32'(W_FRZ_MD));
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   chk("rstmd_c1", 32'(ctl), 32'(W_FRZ_MD));
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   chk("rstmd_c2", 32'(ctl), 32'(W_FRZ_MD));
    rst = 1'b1;
    #1;
    chk("rstmd_async", 32'(ctl), 32'(W_RESET));
    chk("rstmd_stall_cycles", pif.stall_cycles, 32'd0);
    @(negedge clk); rst = 1'b0;
    apply(1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   chk("rstmd_run", 32'(ctl), 32'(W_BUBBLE));
    idle();                                                            chk("rstmd_idle", 32'(ctl), 32'(W_RUN));
`ifndef PIPE_CTRL_PERF_EN
    chk("perf_off_stall", pif.stall_cycles, 32'd0);
    chk("perf_off_flush", pif.flush_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
